// File: rtl/hex_disp_pkg.sv
// rtl/hex_disp_pkg.sv - glyph table, decode helper and width constants for the hex display scanner
package hex_disp_pkg;

    localparam int DEF_NUM_DIGITS   = 8;
    localparam int DEF_SLOT_CYCLES  = 50000;
    localparam int DEF_BLINK_FRAMES = 64;
    localparam int DEF_SLOT_W       = $clog2(DEF_SLOT_CYCLES);
    localparam int DEF_IDX_W        = $clog2(DEF_NUM_DIGITS);
    localparam int DEF_FRAME_W      = $clog2(DEF_BLINK_FRAMES);

    // Active-high glyphs, bit0=a .. bit6=g; entry 0 is the rightmost slice
    localparam logic [15:0][6:0] GLYPHS = {
        7'h71, 7'h79, 7'h5E, 7'h58, 7'h7C, 7'h77, 7'h67, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        return GLYPHS[nibble];
    endfunction

endpackage

// File: rtl/hex_seg_decode.sv
// rtl/hex_seg_decode.sv - nibble to active-high 7-segment glyph
module hex_seg_decode
    import hex_disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] glyph
);

    assign glyph = hex_to_seg(nibble);

endmodule

// File: rtl/hex_display_scanner.sv
// rtl/hex_display_scanner.sv - multiplexed N-digit hex display driver with tear-free double buffering
module hex_display_scanner
    import hex_disp_pkg::*;
#(
    parameter int NUM_DIGITS     = 8,
    parameter int SLOT_CYCLES    = 50000,
    parameter int GUARD_CYCLES   = 500,
    parameter int BLINK_FRAMES   = 64,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                    csi_clk,
    input  logic                    rsi_reset_n,
    input  logic                    upd_valid,
    output logic                    upd_ready,
    input  logic [4*NUM_DIGITS-1:0] upd_value,
    input  logic [NUM_DIGITS-1:0]   upd_dp,
    input  logic [NUM_DIGITS-1:0]   upd_blank,
    input  logic [NUM_DIGITS-1:0]   upd_blink,
    input  logic                    lz_en,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   dig_en,
    output logic                    frame_done
);

    localparam int SLOT_W  = cnt_width(SLOT_CYCLES);
    localparam int IDX_W   = cnt_width(NUM_DIGITS);
    localparam int FRAME_W = cnt_width(BLINK_FRAMES);

    localparam logic [SLOT_W-1:0]     SLOT_LAST  = SLOT_W'(SLOT_CYCLES - 1);
    localparam logic [SLOT_W-1:0]     GUARD_END  = SLOT_W'(GUARD_CYCLES);
    localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [FRAME_W-1:0]    FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);
    localparam logic [6:0]            SEG_OFF    = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic                  DP_OFF     = SEG_ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] DIG_OFF    = DIG_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : '0;

    logic [SLOT_W-1:0]       slot_cnt, slot_nxt;
    logic [IDX_W-1:0]        dig_idx, idx_nxt;
    logic [FRAME_W-1:0]      frame_cnt;
    logic                    blink_phase, phase_nxt;
    logic                    pending_full;
    logic [4*NUM_DIGITS-1:0] pend_value, disp_value, disp_value_nxt;
    logic [NUM_DIGITS-1:0]   pend_dp, pend_blank, pend_blink;
    logic [NUM_DIGITS-1:0]   disp_dp, disp_blank, disp_blink;
    logic [NUM_DIGITS-1:0]   disp_dp_nxt, disp_blank_nxt, disp_blink_nxt;

    logic slot_wrap, frame_wrap, accept, commit;
    logic [3:0]            cur_nibble;
    logic [6:0]            cur_glyph;
    logic                  cur_dark, cur_dp, zero_run, guard, lit;
    logic [6:0]            seg_hi;
    logic                  dp_hi;
    logic [NUM_DIGITS-1:0] dig_on;

    assign upd_ready  = !pending_full;
    assign accept     = upd_valid && !pending_full;
    assign slot_wrap  = (slot_cnt == SLOT_LAST);
    assign frame_wrap = slot_wrap && (dig_idx == IDX_LAST);
    assign commit     = frame_wrap && pending_full;

    assign slot_nxt = slot_wrap ? '0 : slot_cnt + 1'b1;
    assign idx_nxt  = !slot_wrap ? dig_idx : ((dig_idx == IDX_LAST) ? '0 : dig_idx + 1'b1);
    assign phase_nxt = (frame_wrap && frame_cnt == FRAME_LAST) ? !blink_phase : blink_phase;

    assign disp_value_nxt = commit ? pend_value : disp_value;
    assign disp_dp_nxt    = commit ? pend_dp    : disp_dp;
    assign disp_blank_nxt = commit ? pend_blank : disp_blank;
    assign disp_blink_nxt = commit ? pend_blink : disp_blink;

    // Outputs are rendered from next-cycle state so they line up with the counters
    always_comb begin
        cur_nibble = 4'h0;
        cur_dark   = 1'b0;
        cur_dp     = 1'b0;
        zero_run   = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (disp_value_nxt[4*i +: 4] == 4'h0);
            if (idx_nxt == IDX_W'(i)) begin
                cur_nibble = disp_value_nxt[4*i +: 4];
                cur_dp     = disp_dp_nxt[i];
                cur_dark   = disp_blank_nxt[i]
                          || (disp_blink_nxt[i] && phase_nxt)
                          || (lz_en && (i > 0) && zero_run);
            end
        end
    end

    hex_seg_decode u_decode (
        .nibble (cur_nibble),
        .glyph  (cur_glyph)
    );

    assign guard  = (slot_nxt < GUARD_END);
    assign lit    = !guard && !cur_dark;
    assign seg_hi = lit ? cur_glyph : 7'h00;
    assign dp_hi  = lit && cur_dp;
    assign dig_on = guard ? '0 : (NUM_DIGITS'(1) << idx_nxt);

    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            slot_cnt     <= '0;
            dig_idx      <= '0;
            frame_cnt    <= '0;
            blink_phase  <= 1'b0;
            pending_full <= 1'b0;
            pend_value   <= '0;
            pend_dp      <= '0;
            pend_blank   <= '0;
            pend_blink   <= '0;
            disp_value   <= '0;
            disp_dp      <= '0;
            disp_blank   <= '0;
            disp_blink   <= '0;
            frame_done   <= 1'b0;
            seg          <= SEG_OFF;
            dp           <= DP_OFF;
            dig_en       <= DIG_OFF;
        end else begin
            slot_cnt    <= slot_nxt;
            dig_idx     <= idx_nxt;
            blink_phase <= phase_nxt;
            frame_done  <= frame_wrap;
            if (frame_wrap)
                frame_cnt <= (frame_cnt == FRAME_LAST) ? '0 : frame_cnt + 1'b1;
            if (commit) begin
                disp_value   <= pend_value;
                disp_dp      <= pend_dp;
                disp_blank   <= pend_blank;
                disp_blink   <= pend_blink;
                pending_full <= 1'b0;
            end
            if (accept) begin
                pend_value   <= upd_value;
                pend_dp      <= upd_dp;
                pend_blank   <= upd_blank;
                pend_blink   <= upd_blink;
                pending_full <= 1'b1;
            end
            seg    <= SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
            dp     <= SEG_ACTIVE_LOW ? !dp_hi : dp_hi;
            dig_en <= DIG_ACTIVE_LOW ? ~dig_on : dig_on;
        end
    end

endmodule
